// File: rtl/ddr_axi_port_arbiter.sv
// ddr_axi_port_arbiter: N-to-1 AXI4 arbiter onto the DDR controller slave port.
// Define DDR_ARB_CALIB_GATE_EN to hold off grants until synchronised ddr_calib_done.
module ddr_axi_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ID_WIDTH = 4,
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32,
  parameter int WFIFO_DEPTH = 4,
  localparam int PW = NUM_PORTS > 2 ? $clog2(NUM_PORTS) : 1,
  localparam int UW = ID_WIDTH - PW,
  localparam int AXW = ADDR_WIDTH + 24 + UW,
  localparam int MXW = ID_WIDTH + ADDR_WIDTH + 24,
  localparam int WW = DATA_WIDTH * 9 / 8 + 1,
  localparam int BW = UW + 2,
  localparam int RW = UW + DATA_WIDTH + 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ddr_calib_done,
  input  logic [NUM_PORTS*AXW-1:0]  s_aw,
  input  logic [NUM_PORTS-1:0]      s_awvalid,
  output logic [NUM_PORTS-1:0]      s_awready,
  input  logic [NUM_PORTS*WW-1:0]   s_w,
  input  logic [NUM_PORTS-1:0]      s_wvalid,
  output logic [NUM_PORTS-1:0]      s_wready,
  output logic [NUM_PORTS*BW-1:0]   s_b,
  output logic [NUM_PORTS-1:0]      s_bvalid,
  input  logic [NUM_PORTS-1:0]      s_bready,
  input  logic [NUM_PORTS*AXW-1:0]  s_ar,
  input  logic [NUM_PORTS-1:0]      s_arvalid,
  output logic [NUM_PORTS-1:0]      s_arready,
  output logic [NUM_PORTS*RW-1:0]   s_r,
  output logic [NUM_PORTS-1:0]      s_rvalid,
  input  logic [NUM_PORTS-1:0]      s_rready,
  output logic [MXW-1:0]            m_aw,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [WW-1:0]             m_w,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [ID_WIDTH+1:0]       m_b,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [MXW-1:0]            m_ar,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [ID_WIDTH+DATA_WIDTH+2:0] m_r,
  input  logic                      m_rvalid,
  output logic                      m_rready
);
  localparam int FAW = WFIFO_DEPTH > 1 ? $clog2(WFIFO_DEPTH) : 1;
  localparam int CW = PW + $clog2(WFIFO_DEPTH) + 1;
  typedef enum logic {IDLE, GRANT} state_t;
  logic gate, run, full, empty, push, pop;
  logic [PW-1:0] head, bp, rp_id;
  logic [PW-1:0] fifo [WFIFO_DEPTH];
  logic [FAW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [1:0][NUM_PORTS*AXW-1:0] c_spl;
  logic [1:0][NUM_PORTS-1:0] c_sv, c_sr;
  logic [1:0][MXW-1:0] c_mpl;
  logic [1:0] c_mv, c_mr, c_en;
`ifdef DDR_ARB_CALIB_GATE_EN
  logic [1:0] calib_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) calib_q <= '0;
    else calib_q <= {calib_q[0], ddr_calib_done};
  assign gate = calib_q[1];
`else
  logic unused_calib;
  assign unused_calib = ddr_calib_done;
  assign gate = 1'b1;
`endif
  assign run = !rst;
  assign c_spl = {s_ar, s_aw};
  assign c_sv = {s_arvalid, s_awvalid};
  assign c_mr = {m_arready, m_awready};
  assign c_en = {gate, gate && !full};
  assign {s_arready, s_awready} = c_sr;
  assign {m_arvalid, m_awvalid} = c_mv;
  assign {m_ar, m_aw} = c_mpl;
  // Channel 0 is AW, channel 1 is AR; each is an independent round-robin FSM.
  for (genvar c = 0; c < 2; c++) begin : ch
    state_t state, state_nx;
    logic [PW-1:0] g, last, win;
    logic [AXW-1:0] sel;
    logic [NUM_PORTS-1:0] rdy;
    int best;
    always_comb begin
      win = last;
      best = NUM_PORTS;
      for (int i = 0; i < NUM_PORTS; i++)
        if (c_sv[c][i] && (i + 2*NUM_PORTS - 1 - int'(last)) % NUM_PORTS < best) begin
          best = (i + 2*NUM_PORTS - 1 - int'(last)) % NUM_PORTS;
          win = PW'(i);
        end
    end
    always_comb begin
      state_nx = state == IDLE ? (c_en[c] && |c_sv[c] ? GRANT : IDLE) : (c_mr[c] ? IDLE : GRANT);
      sel = '0;
      rdy = '0;
      for (int i = 0; i < NUM_PORTS; i++)
        if (g == PW'(i)) begin
          sel = c_spl[c][i*AXW +: AXW];
          rdy[i] = state == GRANT && c_mr[c];
        end
    end
    assign c_sr[c] = rdy;
    assign c_mv[c] = state == GRANT;
    assign c_mpl[c] = {g, sel};
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        state <= IDLE;
        g <= '0;
        last <= PW'(NUM_PORTS - 1);
      end else begin
        state <= state_nx;
        if (state == IDLE) g <= win;
        if (state == GRANT && c_mr[c]) last <= g;
      end
  end
  assign full = cnt == CW'(WFIFO_DEPTH);
  assign empty = cnt == '0;
  assign push = m_awvalid && m_awready;
  assign pop = m_wvalid && m_wready && m_w[0];
  assign head = fifo[rp];
  always_ff @(posedge clk)
    if (push) fifo[wp] <= m_aw[MXW-1 -: PW];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp == FAW'(WFIFO_DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop) rp <= rp == FAW'(WFIFO_DEPTH - 1) ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  assign bp = m_b[ID_WIDTH+1 -: PW];
  assign rp_id = m_r[ID_WIDTH+DATA_WIDTH+2 -: PW];
  assign s_b = {NUM_PORTS{m_b[BW-1:0]}};
  assign s_r = {NUM_PORTS{m_r[RW-1:0]}};
  // Responses tagged with a nonexistent port keep ready high so they drain.
  always_comb begin
    m_w = '0;
    m_wvalid = 1'b0;
    s_wready = '0;
    s_bvalid = '0;
    m_bready = run;
    s_rvalid = '0;
    m_rready = run;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (head == PW'(i)) begin
        m_w = s_w[i*WW +: WW];
        m_wvalid = !empty && s_wvalid[i];
        s_wready[i] = !empty && m_wready;
      end
      if (bp == PW'(i)) begin
        s_bvalid[i] = run && m_bvalid;
        m_bready = run && s_bready[i];
      end
      if (rp_id == PW'(i)) begin
        s_rvalid[i] = run && m_rvalid;
        m_rready = run && s_rready[i];
      end
    end
  end
endmodule

// File: tb/tb_ddr_axi_port_arbiter.sv
// tb_ddr_axi_port_arbiter: randomized directed bench for the 3-port arbiter against a queue/round-robin model.
module tb_ddr_axi_port_arbiter;
  localparam int N = 3, IDW = 4, ADW = 28, DW = 32, D = 4;
  localparam int PW = 2, UW = IDW - PW, AXW = ADW + 24 + UW, MXW = IDW + ADW + 24;
  localparam int WW = DW * 9 / 8 + 1, BW = UW + 2, RW = UW + DW + 3;
  logic clk = 1'b0, rst, calib;
  logic [N*AXW-1:0] s_aw, s_ar;
  logic [N-1:0] s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [N-1:0] s_arvalid, s_arready, s_rvalid, s_rready;
  logic [N*WW-1:0] s_w;
  logic [N*BW-1:0] s_b;
  logic [N*RW-1:0] s_r;
  logic [MXW-1:0] m_aw, m_ar;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;
  logic [WW-1:0] m_w;
  logic [IDW+1:0] m_b;
  logic [IDW+DW+2:0] m_r;
  int checks = 0, errors = 0;
  int wq[$];
  int bc[N], blen[N];
  logic [AXW-1:0] pl [N];
  logic [WW-1:0] beat [N][4];

  ddr_axi_port_arbiter #(.NUM_PORTS(N), .ID_WIDTH(IDW), .ADDR_WIDTH(ADW), .DATA_WIDTH(DW), .WFIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .ddr_calib_done(calib),
    .s_aw(s_aw), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_w(s_w), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_b(s_b), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_ar(s_ar), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_r(s_r), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_aw(m_aw), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_w(m_w), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_b(m_b), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_ar(m_ar), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_r(m_r), .m_rvalid(m_rvalid), .m_rready(m_rready));

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int rr(input int last, input logic [N-1:0] m);
    for (int k = 1; k <= N; k++) if (m[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [AXW-1:0] rnd_pl(input logic [7:0] len);
    logic [AXW-1:0] v;
    v = AXW'({$urandom, $urandom});
    v[23:16] = len;
    return v;
  endfunction

  task automatic do_aw(input int p, input logic [7:0] len);
    logic [AXW-1:0] v;
    int n;
    v = rnd_pl(len);
    s_aw[p*AXW +: AXW] = v;
    s_awvalid = '0;
    s_awvalid[p] = 1'b1;
    m_awready = 1'b1;
    n = 0;
    tick;
    while (!m_awvalid && n < 20) begin tick; n++; end
    chk("aw_grant", m_aw, {PW'(p), v});
    tick;
    s_awvalid = '0;
    wq.push_back(p);
    blen[p] = int'(len) + 1;
    bc[p] = 0;
  endtask

  initial begin
    int n, h, p5, done, cyc, last_ar, exp_g, bp, rq;
    logic [N-1:0] mask;
    logic [AXW-1:0] v5;
    logic [IDW-1:0] bid, rid;
    logic [1:0] bresp, rresp;
    logic [DW-1:0] rdata;
    logic rlast;
    rst = 1'b1; calib = 1'b0;
    s_aw = '0; s_ar = '0; s_w = '0;
    s_awvalid = '1; s_arvalid = '1; s_wvalid = '1; s_bready = '1; s_rready = '1;
    m_awready = 1'b1; m_arready = 1'b1; m_wready = 1'b1;
    m_b = '0; m_bvalid = 1'b1; m_r = '0; m_rvalid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {m_awvalid, m_arvalid, m_wvalid, m_bready, m_rready,
                          s_awready, s_arready, s_wready, s_bvalid, s_rvalid}, 0);
    s_awvalid = '0; s_arvalid = '0; s_wvalid = '0; m_bvalid = 1'b0; m_rvalid = 1'b0;
    rst = 1'b0;
    for (int p = 0; p < N; p++) begin bc[p] = 0; blen[p] = 0; end
    tick;
`ifdef DDR_ARB_CALIB_GATE_EN
    s_aw[AXW-1:0] = rnd_pl(0);
    s_awvalid = 3'b001;
    repeat (100) begin tick; chk("calib_hold", m_awvalid, 0); end
    calib = 1'b1;
    tick; tick;
    chk("calib_wait", m_awvalid, 0);
    tick;
    chk("calib_grant", m_awvalid, 1);
    tick;
    s_awvalid = '0;
    s_w[WW-1:0] = {DW'($urandom), 4'hf, 1'b1};
    s_wvalid = 3'b001;
    tick;
    s_wvalid = '0;
`endif
    // Round-robin AR: six rounds of all-request, then random masks with occasional stalls
    last_ar = N - 1;
    for (int it = 0; it < 18; it++) begin
      mask = it < 6 ? 3'b111 : 3'($urandom_range(1, 7));
      for (int p = 0; p < N; p++) begin pl[p] = rnd_pl(8'($urandom)); s_ar[p*AXW +: AXW] = pl[p]; end
      s_arvalid = mask;
      m_arready = (it >= 6 && ($urandom % 2) == 1) ? 1'b0 : 1'b1;
      n = 0;
      tick;
      while (!m_arvalid && n < 20) begin tick; n++; end
      exp_g = rr(last_ar, mask);
      chk("ar_latency", n, 0);
      chk("ar_grant", m_ar, {PW'(exp_g), pl[exp_g]});
      if (!m_arready) begin
        chk("ar_stall_ready", s_arready, 0);
        tick;
        chk("ar_stall_hold", m_ar, {PW'(exp_g), pl[exp_g]});
        m_arready = 1'b1;
        #1;
      end
      chk("ar_ready", s_arready, N'(1) << exp_g);
      tick;
      chk("ar_idle", m_arvalid, 0);
      last_ar = exp_g;
    end
    s_arvalid = '0;
    // W ordering: port 1 burst of 4 then port 0 single beat, random backpressure
    do_aw(1, 3);
    do_aw(0, 0);
    for (int p = 0; p < N; p++)
      for (int b = 0; b < 4; b++) beat[p][b] = {DW'($urandom), 4'($urandom), b == blen[p] - 1};
    done = 0; cyc = 0;
    while (done < 5 && cyc < 100) begin
      for (int p = 0; p < N; p++) begin
        s_wvalid[p] = bc[p] < blen[p];
        s_w[p*WW +: WW] = beat[p][bc[p] < 4 ? bc[p] : 0];
      end
      m_wready = cyc > 40 ? 1'b1 : 1'($urandom % 2);
      #1;
      h = wq[0];
      chk("w_valid", m_wvalid, 1);
      chk("w_data", m_w, beat[h][bc[h]]);
      chk("w_ready", s_wready, m_wready ? N'(1) << h : N'(0));
      @(posedge clk);
      if (m_wready) begin
        if (beat[h][bc[h]][0]) void'(wq.pop_front());
        bc[h]++;
        done++;
      end
      #1;
      cyc++;
    end
    chk("w_beats", done, 5);
    s_wvalid = '1;
    #1;
    chk("w_empty", m_wvalid, 0);
    s_wvalid = '0;
    // Fill the write-order FIFO; the fifth AW waits for a wlast
    for (int k = 0; k < D; k++) do_aw($urandom_range(0, N - 1), 0);
    p5 = $urandom_range(0, N - 1);
    v5 = rnd_pl(0);
    s_aw[p5*AXW +: AXW] = v5;
    s_awvalid = '0;
    s_awvalid[p5] = 1'b1;
    repeat (6) begin tick; chk("aw_full_block", m_awvalid, 0); end
    h = wq[0];
    s_wvalid = '0;
    s_wvalid[h] = 1'b1;
    s_w[h*WW +: WW] = {DW'($urandom), 4'hf, 1'b1};
    m_wready = 1'b1;
    #1;
    chk("full_pop_ready", s_wready, N'(1) << h);
    tick;
    s_wvalid = '0;
    void'(wq.pop_front());
    chk("aw_pop_cycle", m_awvalid, 0);
    n = 0;
    tick;
    while (!m_awvalid && n < 20) begin tick; n++; end
    chk("aw_fifth", m_aw, {PW'(p5), v5});
    tick;
    s_awvalid = '0;
    wq.push_back(p5);
    n = 0;
    while (wq.size() > 0 && n < 10) begin
      h = wq[0];
      s_wvalid = '0;
      s_wvalid[h] = 1'b1;
      s_w[h*WW +: WW] = {DW'($urandom), 4'hf, 1'b1};
      #1;
      chk("drain_order", s_wready, N'(1) << h);
      tick;
      s_wvalid = '0;
      void'(wq.pop_front());
      n++;
    end
    // B/R steering by upper ID bits; port 3 does not exist and is drained
    for (int it = 0; it < 24; it++) begin
      bid = it == 0 ? 4'b1101 : it == 1 ? 4'b0110 : 4'($urandom);
      bresp = 2'($urandom);
      m_b = {bid, bresp};
      m_bvalid = it < 2 ? 1'b1 : 1'($urandom);
      s_bready = it == 1 ? 3'b101 : 3'($urandom);
      rid = 4'($urandom); rdata = $urandom; rresp = 2'($urandom); rlast = 1'($urandom);
      m_r = {rid, rdata, rresp, rlast};
      m_rvalid = 1'($urandom);
      s_rready = 3'($urandom);
      #1;
      bp = int'(bid) >> UW;
      rq = int'(rid) >> UW;
      chk("b_valid", s_bvalid, (m_bvalid && bp < N) ? N'(1) << bp : N'(0));
      chk("b_ready", m_bready, bp < N ? s_bready[bp % N] : 1'b1);
      chk("b_payload", s_b[(bp % N)*BW +: BW], {bid[UW-1:0], bresp});
      chk("r_valid", s_rvalid, (m_rvalid && rq < N) ? N'(1) << rq : N'(0));
      chk("r_ready", m_rready, rq < N ? s_rready[rq % N] : 1'b1);
      chk("r_payload", s_r[(rq % N)*RW +: RW], {rid[UW-1:0], rdata, rresp, rlast});
      tick;
    end
    m_bvalid = 1'b0; m_rvalid = 1'b0;
    // Reset during the second beat of a 4-beat burst
    do_aw(2, 3);
    s_wvalid = 3'b100;
    s_w[2*WW +: WW] = {DW'($urandom), 4'hf, 1'b0};
    m_wready = 1'b1;
    tick;
    s_w[2*WW +: WW] = {DW'($urandom), 4'hf, 1'b0};
    #1;
    chk("rst_beat2_valid", m_wvalid, 1);
    s_awvalid = '1; s_arvalid = '1; m_awready = 1'b0; m_arready = 1'b0;
    m_b = {2'b00, 4'h0}; m_bvalid = 1'b1; s_bready = '1;
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {m_awvalid, m_arvalid, m_wvalid, m_bready, m_rready,
                            s_awready, s_arready, s_wready, s_bvalid, s_rvalid}, 0);
    tick; tick;
    rst = 1'b0;
    wq.delete();
    tick;
    chk("rst_fifo_wvalid", m_wvalid, 0);
    chk("rst_fifo_wready", s_wready, 0);
    chk("rst_ar_restart", m_ar[MXW-1 -: PW], 0);
    chk("rst_aw_restart", m_aw[MXW-1 -: PW], 0);
    chk("rst_b_release", s_bvalid, 3'b001);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
